pwm_multi_channel: RTL and testbench
====================================

// Module: pwm_multi_channel
// PURPOSE
// Parametrised multi-channel PWM generator; next generation of the single-channel 4-bit pwm_top.
// One shared prescaler and period counter drive CHANNELS independent duty comparators.
// Duty writes are double-buffered and applied only at a period boundary, so outputs never glitch.
// Supports edge-aligned (sawtooth) and center-aligned (triangle) counting; sits between the register/control logic and the LED/dimmer pins.
// PARAMETERS
// CHANNELS    4   number of PWM outputs (1..16)
// WIDTH       8   bit width of counter, period and duty values
// PRESCALE_W  16  bit width of the clock prescaler compare value
// PORTS
// clk           in   1                 system clock, all logic on rising edge
// reset         in   1                 synchronous, active-low reset
// enable        in   1                 1 = run; 0 = hold counters at 0 and force outputs low
// center_mode   in   1                 0 = edge-aligned, 1 = center-aligned; sampled at boundary
// prescale      in   PRESCALE_W        tick every prescale+1 clk cycles
// period        in   WIDTH             counter top value P; sampled at boundary
// duty_wr       in   1                 write strobe for the duty shadow register
// duty_wr_ch    in   4                 channel index for the write
// duty_wr_data  in   WIDTH             duty value D for the write
// pwm           out  CHANNELS          PWM outputs, registered
// period_end    out  1                 one-clk pulse on each period boundary
// count_dbg     out  WIDTH             current period counter value
// BEHAVIOUR
// - Reset (reset=0 at clk edge) clears:
//   - pwm=0, period_end=0, count_dbg=0, prescaler=0, direction=up
//   - all duty shadow and active regs = 0; active period = 0; active mode = edge
//   - reset mid-period aborts the period immediately; no partial output afterwards.
// - Prescaler: presc_cnt counts 0..prescale. tick=1 in the cycle presc_cnt==prescale; presc_cnt then wraps to 0.
//   - prescale=0 gives tick every cycle. A prescale change takes effect on the next compare.
// - Edge mode: count advances on tick, 0,1,..,P,0,... Period = (P+1) ticks.
// - Center mode: count goes 0 up to P, then down to 1, then 0. Period = 2P ticks.
//   - Direction flips on the tick where count reaches P, and again where it reaches 0.
//   - P=0 in center mode: count stays 0 and every tick is a boundary.
// - Boundary = the tick on which count moves to 0 and starts a new up-run. At that clk edge:
//   - active_duty[i] <= shadow[i]; active period <= period; active mode <= center_mode
//   - period_end=1 for exactly that one clk cycle
// - Duty writes: on duty_wr=1, shadow[duty_wr_ch] <= duty_wr_data.
//   - duty_wr_ch >= CHANNELS: write ignored.
//   - Write in the same cycle as a boundary: active takes the OLD shadow value; the new value applies at the next boundary.
// - Output: pwm[i] <= enable & (count < active_duty[i]). One clk latency from count_dbg.
//   - D=0: output constantly low.
//   - D>P (edge mode) or D>P (center mode): output constantly high, with no low glitch at the boundary.
//   - Edge mode high time = D ticks per period.
//   - Center mode high time = 2D-1 ticks for 1<=D<=P, centred on count=0.
// - enable=0: presc_cnt=0, count=0, dir=up, pwm=0, period_end=0.
//   - While disabled, active regs load from shadow/period/center_mode every cycle.
//   - On the first cycle with enable=1, counting starts from count 0 and the values are already active.
// - Widths: all comparisons unsigned in WIDTH bits; count never exceeds the active P.
//   - If period is lowered below count mid-period, the active P is unaffected until the boundary.
// TESTING (CHANNELS=4, WIDTH=8)
// 1. Edge, prescale=0, P=9, D0=3 -> pwm[0] high 3 of every 10 clks; period_end every 10 clks; count_dbg wraps 9->0.
// 2. D1=0, D2=10, D3=255 with P=9 -> pwm[1] always 0; pwm[2] and pwm[3] always 1, no glitch across period_end.
// 3. prescale=4, P=4, D0=2 -> pwm[0] high 10 clks of every 25; period_end every 25 clks.
// 4. Change D1 3->5 at mid-period, then again on a period_end cycle -> old value holds until next boundary; boundary-cycle write lands one period later.
// 5. Center, prescale=0, P=4, D0=2 -> count 0,1,2,3,4,3,2,1; pwm[0] high 3 of 8 clks, symmetric about count 0.
// 6. reset=0 mid-period, then enable=0 for 5 clks, then enable=1 -> all outputs 0 during both; counting restarts at 0; duty_wr_ch=7 write has no effect.

Source files
------------

// File: rtl/pwm_multi_channel_if.sv
// Control, duty-write and output signals of pwm_multi_channel.
// The master side drives the controls; the PWM block is the slave.
interface pwm_multi_channel_if #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16
) ();
  logic                  enable;
  logic                  center_mode;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      period;
  logic                  duty_wr;
  logic [3:0]            duty_wr_ch;
  logic [WIDTH-1:0]      duty_wr_data;
  logic [CHANNELS-1:0]   pwm;
  logic                  period_end;
  logic [WIDTH-1:0]      count_dbg;

  modport master (
    output enable, center_mode, prescale, period, duty_wr, duty_wr_ch, duty_wr_data,
    input  pwm, period_end, count_dbg
  );

  modport slave (
    input  enable, center_mode, prescale, period, duty_wr, duty_wr_ch, duty_wr_data,
    output pwm, period_end, count_dbg
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared prescaler and period counter (edge or center aligned)
// feeding per-channel duty comparators with double-buffered duty registers.
module pwm_multi_channel #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pwm_multi_channel_if.slave   bus
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]      count_q, count_d;
  dir_e                  dir_q, dir_d;
  logic [WIDTH-1:0]      per_q;
  logic                  mode_q;
  logic                  pend_q;
  logic                  boundary;
  logic                  load;
  logic [CHANNELS-1:0]   pwm_w;

  // Counter next state; boundary marks the tick that starts a new up-run at 0.
  always_comb begin
    presc_d  = presc_q;
    count_d  = count_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (!bus.enable) begin
      presc_d = '0;
      count_d = '0;
      dir_d   = DIR_UP;
    end else if (presc_q == bus.prescale) begin
      presc_d = '0;
      if (!mode_q) begin
        if (count_q == per_q) begin
          count_d  = '0;
          boundary = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else if (per_q == '0) begin
        count_d  = '0;
        dir_d    = DIR_UP;
        boundary = 1'b1;
      end else if (dir_q == DIR_UP) begin
        count_d = count_q + 1'b1;
        if (count_d == per_q) dir_d = DIR_DOWN;
      end else begin
        count_d = count_q - 1'b1;
        if (count_d == '0) begin
          dir_d    = DIR_UP;
          boundary = 1'b1;
        end
      end
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  assign load = boundary | ~bus.enable;

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      count_q <= '0;
      dir_q   <= DIR_UP;
      per_q   <= '0;
      mode_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      pend_q  <= boundary;
      if (load) begin
        per_q  <= bus.period;
        mode_q <= bus.center_mode;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] shadow_q;
      logic [WIDTH-1:0] active_q;
      logic             pwm_q;

      // Active duty loads the pre-write shadow, so a boundary-cycle write waits a period.
      always_ff @(posedge clk) begin
        if (!reset) begin
          shadow_q <= '0;
          active_q <= '0;
          pwm_q    <= 1'b0;
        end else begin
          if (bus.duty_wr && (bus.duty_wr_ch == 4'(gi))) shadow_q <= bus.duty_wr_data;
          if (load) active_q <= shadow_q;
          pwm_q <= bus.enable & (count_q < active_q);
        end
      end

      assign pwm_w[gi] = pwm_q;
    end
  endgenerate

  assign bus.pwm        = pwm_w;
  assign bus.period_end = pend_q;
  assign bus.count_dbg  = count_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: vector table, hand sequences and random stimulus
// checked cycle by cycle against a period-position reference model.
module tb_pwm_multi_channel;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pwm_multi_channel_if #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW)) bus ();
  pwm_multi_channel #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: position k within the period, mapped to a count value.
  int m_presc = 0;
  int m_k     = 0;
  int m_p     = 0;
  bit m_mode  = 1'b0;
  int m_sh[CH];
  int m_act[CH];
  int e_pwm = 0;
  int e_pend = 0;
  int e_cnt = 0;

  function automatic int pos2cnt(input int k, input int p, input bit mode);
    if (!mode || k <= p) return k;
    return 2 * p - k;
  endfunction

  function automatic int plen(input int p, input bit mode);
    if (!mode) return p + 1;
    if (p == 0) return 1;
    return 2 * p;
  endfunction

  task automatic model_step();
    int c;
    bit bnd;
    bit ld;
    if (!reset) begin
      m_presc = 0; m_k = 0; m_p = 0; m_mode = 1'b0;
      for (int i = 0; i < CH; i++) begin m_sh[i] = 0; m_act[i] = 0; end
      e_pwm = 0; e_pend = 0; e_cnt = 0;
    end else begin
      c = pos2cnt(m_k, m_p, m_mode);
      e_pwm = 0;
      for (int i = 0; i < CH; i++)
        if (bus.enable && c < m_act[i]) e_pwm |= (1 << i);
      bnd = 1'b0;
      ld  = !bus.enable;
      if (!bus.enable) begin
        m_presc = 0; m_k = 0;
      end else if (m_presc == int'(bus.prescale)) begin
        m_presc = 0;
        if (m_k + 1 >= plen(m_p, m_mode)) begin m_k = 0; bnd = 1'b1; ld = 1'b1; end
        else m_k++;
      end else begin
        m_presc = (m_presc + 1) % 65536;
      end
      if (ld) begin
        m_p = int'(bus.period);
        m_mode = bus.center_mode;
        for (int i = 0; i < CH; i++) m_act[i] = m_sh[i];
      end
      if (bus.duty_wr && int'(bus.duty_wr_ch) < CH) m_sh[bus.duty_wr_ch] = int'(bus.duty_wr_data);
      e_pend = bnd ? 1 : 0;
      e_cnt  = pos2cnt(m_k, m_p, m_mode);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("count_dbg", int'(bus.count_dbg), e_cnt);
    check("pwm", int'(bus.pwm), e_pwm);
    check("period_end", int'(bus.period_end), e_pend);
  endtask

  typedef struct {
    bit c; int ps; int per;
    int d0; int d1; int d2; int d3;
    int n;
    int h0; int h1; int h2; int h3;
    int pe;
  } vec_t;

  function automatic vec_t mk(input bit c, input int ps, input int per,
                              input int d0, input int d1, input int d2, input int d3,
                              input int n, input int h0, input int h1, input int h2,
                              input int h3, input int pe);
    vec_t v;
    v.c = c; v.ps = ps; v.per = per;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.n = n; v.h0 = h0; v.h1 = h1; v.h2 = h2; v.h3 = h3; v.pe = pe;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int d[CH];
    int hi[CH];
    int pe;
    d = '{v.d0, v.d1, v.d2, v.d3};
    bus.enable = 1'b0;
    bus.center_mode = v.c;
    bus.prescale = PW'(v.ps);
    bus.period = W'(v.per);
    for (int i = 0; i < CH; i++) begin
      bus.duty_wr = 1'b1;
      bus.duty_wr_ch = 4'(i);
      bus.duty_wr_data = W'(d[i]);
      step();
    end
    bus.duty_wr = 1'b0;
    step();
    bus.enable = 1'b1;
    hi = '{0, 0, 0, 0};
    pe = 0;
    for (int c = 0; c < v.n; c++) begin
      step();
      for (int i = 0; i < CH; i++) hi[i] += int'(bus.pwm[i]);
      pe += int'(bus.period_end);
    end
    check($sformatf("vec%0d_high0", idx), hi[0], v.h0);
    check($sformatf("vec%0d_high1", idx), hi[1], v.h1);
    check($sformatf("vec%0d_high2", idx), hi[2], v.h2);
    check($sformatf("vec%0d_high3", idx), hi[3], v.h3);
    check($sformatf("vec%0d_ends", idx), pe, v.pe);
    $display("vec %0d: mode=%0d ps=%0d P=%0d high=%0d/%0d/%0d/%0d ends=%0d",
             idx, v.c, v.ps, v.per, hi[0], hi[1], hi[2], hi[3], pe);
  endtask

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    vecs[0] = mk(1'b0, 0, 9, 3, 0, 10, 255, 20,  6,  0, 20, 20, 2);
    vecs[1] = mk(1'b0, 4, 4, 2, 5, 1,  0,   50, 20, 50, 10,  0, 2);
    vecs[2] = mk(1'b1, 0, 4, 2, 4, 5,  1,   16,  6, 14, 16,  2, 2);
    vecs[3] = mk(1'b1, 1, 3, 1, 2, 3,  4,   24,  4, 12, 20, 24, 2);
    vecs[4] = mk(1'b1, 0, 0, 0, 1, 2,  0,    5,  0,  5,  5,  0, 5);
    vecs[5] = mk(1'b0, 2, 0, 1, 0, 1,  0,    9,  9,  0,  9,  0, 3);

    bus.enable = 1'b0; bus.center_mode = 1'b0; bus.prescale = '0; bus.period = '0;
    bus.duty_wr = 1'b0; bus.duty_wr_ch = '0; bus.duty_wr_data = '0;
    reset = 1'b0;
    repeat (3) step();
    check("rst_pwm", int'(bus.pwm), 0);
    check("rst_count", int'(bus.count_dbg), 0);
    check("rst_end", int'(bus.period_end), 0);
    $display("reset: pwm=%0d count=%0d end=%0d", bus.pwm, bus.count_dbg, bus.period_end);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Duty change mid-period and on the boundary cycle itself.
    bus.enable = 1'b0; bus.center_mode = 1'b0; bus.prescale = '0; bus.period = 8'd9;
    bus.duty_wr = 1'b1; bus.duty_wr_ch = 4'd1; bus.duty_wr_data = 8'd3;
    step();
    bus.duty_wr = 1'b0;
    step();
    bus.enable = 1'b1;
    h = 0;
    for (int c = 0; c < 10; c++) begin
      bus.duty_wr = (c == 4);
      bus.duty_wr_data = 8'd5;
      step();
      h += int'(bus.pwm[1]);
    end
    bus.duty_wr = 1'b0;
    check("mid_write_old_high", h, 3);
    check("mid_write_end", int'(bus.period_end), 1);
    $display("dutyseq period1: high=%0d", h);
    h = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 9) begin
        check("bnd_write_count", int'(bus.count_dbg), 9);
        bus.duty_wr = 1'b1;
        bus.duty_wr_data = 8'd7;
      end
      step();
      h += int'(bus.pwm[1]);
    end
    bus.duty_wr = 1'b0;
    check("mid_write_new_high", h, 5);
    $display("dutyseq period2: high=%0d", h);
    h = 0;
    for (int c = 0; c < 10; c++) begin step(); h += int'(bus.pwm[1]); end
    check("bnd_write_held", h, 5);
    $display("dutyseq period3: high=%0d", h);
    h = 0;
    for (int c = 0; c < 10; c++) begin step(); h += int'(bus.pwm[1]); end
    check("bnd_write_applied", h, 7);
    $display("dutyseq period4: high=%0d", h);

    // Reset mid-period, disabled stretch with an out-of-range write, then restart.
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
    check("midrst_pwm", int'(bus.pwm), 0);
    check("midrst_count", int'(bus.count_dbg), 0);
    reset = 1'b1;
    bus.enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.duty_wr = (c == 1);
      bus.duty_wr_ch = 4'd7;
      bus.duty_wr_data = 8'h55;
      step();
      check("dis_pwm", int'(bus.pwm), 0);
    end
    bus.duty_wr = 1'b0;
    bus.enable = 1'b1;
    step();
    check("restart_count", int'(bus.count_dbg), 1);
    h = int'(bus.pwm);
    for (int c = 0; c < 19; c++) begin step(); h += int'(bus.pwm); end
    check("restart_pwm_low", h, 0);
    $display("restart: count after first tick=%0d pwm sum=%0d", bus.count_dbg, h);

    // Random traffic against the model.
    bus.duty_wr_ch = 4'd0;
    for (int c = 0; c < 3000; c++) begin
      bus.duty_wr = ($urandom_range(0, 99) < 30);
      bus.duty_wr_ch = 4'($urandom_range(0, 7));
      bus.duty_wr_data = 8'($urandom_range(0, 14));
      bus.enable = ($urandom_range(0, 99) >= 3);
      if (!bus.enable && ($urandom_range(0, 1) == 1)) bus.prescale = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 5) bus.period = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 99) < 3) bus.center_mode = ~bus.center_mode;
      reset = ($urandom_range(0, 999) >= 4);
      step();
    end
    $display("random: 3000 cycles applied");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
